// File: rtl/multdiv_sequencer.sv
// -----------------------------------------------------------------------------
// multdiv_sequencer
//   Sequences the multi-cycle multiplier/divider for the single-issue core.
//   A mul/div at issue starts the unit with a one-cycle ctrl_mult/ctrl_div
//   pulse. The front end stalls while the unit runs. Exactly one writeback
//   follows: the unit result goes to rd, or rstatus goes to EXC_REG on an
//   exception or timeout. A flush while the unit is busy drops the operation
//   with no writeback.
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous, active-low reset
//   issue_valid    instruction present at issue this cycle
//   opcode/aluop   instruction fields used to detect mul/div
//   rd             destination register of the issuing instruction
//   md_ready       unit result valid (level)
//   md_exception   unit overflow / divide-by-zero, valid with md_ready
//   flush          pipeline redirect
//   ctrl_mult      one-cycle start pulse, multiply (registered)
//   ctrl_div       one-cycle start pulse, divide (registered)
//   stall          hold PC/fetch/issue (combinational)
//   busy_cycles    BUSY cycle count, 0 outside BUSY
//   wb_en          regfile write enable for the sequencer result
//   wb_rd          writeback register
//   wb_sel_rstatus 1: write rstatus, 0: write unit result
//   rstatus        zero-extended status code, 0 unless an exception is written
// -----------------------------------------------------------------------------
module multdiv_sequencer #(
  parameter int unsigned CNT_W   = 6,
  parameter int unsigned TIMEOUT = 40,
  parameter int unsigned RST_MUL = 4,
  parameter int unsigned RST_DIV = 5,
  parameter int unsigned EXC_REG = 30
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [4:0]       opcode,
  input  logic [4:0]       aluop,
  input  logic [4:0]       rd,
  input  logic             md_ready,
  input  logic             md_exception,
  input  logic             flush,
  output logic             ctrl_mult,
  output logic             ctrl_div,
  output logic             stall,
  output logic [CNT_W-1:0] busy_cycles,
  output logic             wb_en,
  output logic [4:0]       wb_rd,
  output logic             wb_sel_rstatus,
  output logic [31:0]      rstatus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_WB   = 2'd2
  } state_e;

  localparam logic [4:0]       OP_RTYPE  = 5'b00000;
  localparam logic [4:0]       ALU_MUL   = 5'b00110;
  localparam logic [4:0]       ALU_DIV   = 5'b00111;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [4:0]       EXC_RD    = 5'(EXC_REG);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       rd_q, rd_d;
  logic             div_q, div_d;
  logic             ctrl_mult_q, ctrl_mult_d;
  logic             ctrl_div_q, ctrl_div_d;
  logic             wb_en_q, wb_en_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic             wb_sel_q, wb_sel_d;
  logic [31:0]      rstatus_q, rstatus_d;

  logic is_md, is_div_op, start, to_wb, exc_now;

  assign is_div_op = (aluop == ALU_DIV);
  assign is_md     = (opcode == OP_RTYPE) && ((aluop == ALU_MUL) || is_div_op);
  // Flush has priority over a new issue.
  assign start     = (state_q == S_IDLE) && issue_valid && is_md && !flush;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    div_d       = div_q;
    ctrl_mult_d = 1'b0;
    ctrl_div_d  = 1'b0;
    wb_en_d     = 1'b0;
    wb_rd_d     = 5'd0;
    wb_sel_d    = 1'b0;
    rstatus_d   = 32'd0;
    stall       = 1'b0;
    to_wb       = 1'b0;
    exc_now     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        stall = start;
        if (start) begin
          rd_d        = rd;
          div_d       = is_div_op;
          cnt_d       = '0;
          // Registered, so the pulse lands in the first BUSY cycle (cnt==0).
          ctrl_mult_d = !is_div_op;
          ctrl_div_d  = is_div_op;
          state_d     = S_BUSY;
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        cnt_d = (cnt_q == TIMEOUT_C) ? cnt_q : cnt_q + 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else if ((cnt_q != '0) && md_ready) begin
          // A ready result beats a same-cycle timeout.
          to_wb   = 1'b1;
          exc_now = md_exception;
        end else if (cnt_q == TIMEOUT_C) begin
          to_wb   = 1'b1;
          exc_now = 1'b1;
        end
      end
      S_WB: begin
        // Instruction is committed: flush and new issue are both ignored here.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Writeback outputs are registered and loaded on the BUSY->WB transition.
    if (to_wb) begin
      state_d   = S_WB;
      wb_sel_d  = exc_now;
      wb_rd_d   = exc_now ? EXC_RD : rd_q;
      wb_en_d   = exc_now || (rd_q != 5'd0);
      rstatus_d = exc_now ? (div_q ? 32'(RST_DIV) : 32'(RST_MUL)) : 32'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rd_q        <= 5'd0;
      div_q       <= 1'b0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_sel_q    <= 1'b0;
      rstatus_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      div_q       <= div_d;
      ctrl_mult_q <= ctrl_mult_d;
      ctrl_div_q  <= ctrl_div_d;
      wb_en_q     <= wb_en_d;
      wb_rd_q     <= wb_rd_d;
      wb_sel_q    <= wb_sel_d;
      rstatus_q   <= rstatus_d;
    end
  end

  assign ctrl_mult      = ctrl_mult_q;
  assign ctrl_div       = ctrl_div_q;
  assign busy_cycles    = (state_q == S_BUSY) ? cnt_q : '0;
  assign wb_en          = wb_en_q;
  assign wb_rd          = wb_rd_q;
  assign wb_sel_rstatus = wb_sel_q;
  assign rstatus        = rstatus_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multdiv_sequencer
//   Directed bench for multdiv_sequencer. Inputs change 1ns after the rising
//   edge; outputs are sampled 1ns after the falling edge. Expected values are
//   hand-computed constants per step.
// -----------------------------------------------------------------------------
module tb_multdiv_sequencer;

  localparam int CNT_W = 6;

  logic             clock = 1'b0;
  logic             reset;
  logic             issue_valid;
  logic [4:0]       opcode;
  logic [4:0]       aluop;
  logic [4:0]       rd;
  logic             md_ready;
  logic             md_exception;
  logic             flush;
  logic             ctrl_mult;
  logic             ctrl_div;
  logic             stall;
  logic [CNT_W-1:0] busy_cycles;
  logic             wb_en;
  logic [4:0]       wb_rd;
  logic             wb_sel_rstatus;
  logic [31:0]      rstatus;

  int errors = 0;
  int checks = 0;
  int stall_cnt = 0;
  int mult_cnt  = 0;
  int div_cnt   = 0;
  int wben_cnt  = 0;

  multdiv_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .opcode         (opcode),
    .aluop          (aluop),
    .rd             (rd),
    .md_ready       (md_ready),
    .md_exception   (md_exception),
    .flush          (flush),
    .ctrl_mult      (ctrl_mult),
    .ctrl_div       (ctrl_div),
    .stall          (stall),
    .busy_cycles    (busy_cycles),
    .wb_en          (wb_en),
    .wb_rd          (wb_rd),
    .wb_sel_rstatus (wb_sel_rstatus),
    .rstatus        (rstatus)
  );

  always #5 clock = ~clock;

  // Per-test event counters, sampled once per cycle at the falling edge.
  always @(negedge clock) begin
    if (stall)     stall_cnt++;
    if (ctrl_mult) mult_cnt++;
    if (ctrl_div)  div_cnt++;
    if (wb_en)     wben_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_counts();
    stall_cnt = 0;
    mult_cnt  = 0;
    div_cnt   = 0;
    wben_cnt  = 0;
  endtask

  task automatic issue(input logic [4:0] op, input logic [4:0] alu, input logic [4:0] dst);
    issue_valid = 1'b1;
    opcode      = op;
    aluop       = alu;
    rd          = dst;
  endtask

  initial begin
    reset        = 1'b0;
    issue_valid  = 1'b0;
    opcode       = 5'd0;
    aluop        = 5'd0;
    rd           = 5'd0;
    md_ready     = 1'b0;
    md_exception = 1'b0;
    flush        = 1'b0;

    // ---- Reset state ----
    sample();
    check("rst_stall", stall, 0);
    check("rst_busy", busy_cycles, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_ctrl", {ctrl_mult, ctrl_div}, 0);
    check("rst_rstatus", rstatus, 0);
    step();
    reset = 1'b1;
    step();

    // ---- 1: mul rd=5, ready at cnt=8, no exception ----
    clear_counts();
    issue(5'd0, 5'd6, 5'd5);
    sample();
    check("t1_issue_stall", stall, 1);
    step();
    issue_valid = 1'b0;
    sample();
    check("t1_ctrl_mult", ctrl_mult, 1);
    check("t1_ctrl_div", ctrl_div, 0);
    check("t1_cnt0", busy_cycles, 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 8) md_ready = 1'b1;
      sample();
      check("t1_cnt", busy_cycles, k);
      check("t1_stall_busy", stall, 1);
    end
    step();
    md_ready = 1'b0;
    // A new mul in the WB cycle must not be accepted.
    issue(5'd0, 5'd6, 5'd12);
    sample();
    check("t1_wb_en", wb_en, 1);
    check("t1_wb_rd", wb_rd, 5);
    check("t1_wb_sel", wb_sel_rstatus, 0);
    check("t1_wb_rstatus", rstatus, 0);
    check("t1_wb_stall", stall, 0);
    check("t1_stall_cycles", stall_cnt, 10);
    check("t1_mult_pulses", mult_cnt, 1);
    step();
    issue_valid = 1'b0;
    sample();
    check("t1_post_wb_en", wb_en, 0);
    check("t1_wb_issue_ignored", ctrl_mult, 0);
    check("t1_post_stall", stall, 0);

    // ---- 2: div rd=7, ready at cnt=3 with exception ----
    step();
    clear_counts();
    issue(5'd0, 5'd7, 5'd7);
    step();
    issue_valid = 1'b0;
    sample();
    check("t2_ctrl_div", ctrl_div, 1);
    step();
    step();
    step();
    md_ready     = 1'b1;
    md_exception = 1'b1;
    sample();
    check("t2_cnt3", busy_cycles, 3);
    step();
    md_ready     = 1'b0;
    md_exception = 1'b0;
    flush        = 1'b1;   // ignored in WB
    sample();
    check("t2_wb_en", wb_en, 1);
    check("t2_wb_rd", wb_rd, 30);
    check("t2_wb_sel", wb_sel_rstatus, 1);
    check("t2_rstatus", rstatus, 5);
    check("t2_mult_pulses", mult_cnt, 0);
    check("t2_div_pulses", div_cnt, 1);
    step();
    flush = 1'b0;
    sample();
    check("t2_post_wb_en", wb_en, 0);
    check("t2_post_rstatus", rstatus, 0);

    // ---- 3: mul, md_ready never -> timeout at cnt=40 ----
    step();
    clear_counts();
    issue(5'd0, 5'd6, 5'd9);
    step();
    issue_valid = 1'b0;
    for (int k = 1; k <= 40; k++) step();
    sample();
    check("t3_cnt40", busy_cycles, 40);
    check("t3_stall40", stall, 1);
    check("t3_no_wb_yet", wben_cnt, 0);
    step();
    sample();
    check("t3_wb_en", wb_en, 1);
    check("t3_wb_rd", wb_rd, 30);
    check("t3_wb_sel", wb_sel_rstatus, 1);
    check("t3_rstatus", rstatus, 4);
    check("t3_wb_stall", stall, 0);
    check("t3_stall_cycles", stall_cnt, 42);

    // ---- 4: div, flush at cnt=2 ----
    step();
    step();
    clear_counts();
    issue(5'd0, 5'd7, 5'd3);
    step();
    issue_valid = 1'b0;
    step();
    step();
    flush = 1'b1;
    sample();
    check("t4_cnt2", busy_cycles, 2);
    check("t4_flush_stall", stall, 1);
    step();
    flush = 1'b0;
    sample();
    check("t4_after_flush_stall", stall, 0);
    check("t4_after_flush_busy", busy_cycles, 0);
    step();
    step();
    sample();
    check("t4_no_wb", wben_cnt, 0);

    // ---- 5: issue+flush same cycle; mul rd=0, cnt0 ready ignored ----
    step();
    clear_counts();
    issue(5'd0, 5'd6, 5'd4);
    flush = 1'b1;
    sample();
    check("t5_flush_issue_stall", stall, 0);
    step();
    issue_valid = 1'b0;
    flush       = 1'b0;
    sample();
    check("t5_no_start_pulse", ctrl_mult, 0);
    check("t5_no_start_stall", stall, 0);
    step();
    issue(5'd0, 5'd6, 5'd0);
    step();
    issue_valid  = 1'b0;
    md_ready     = 1'b1;
    md_exception = 1'b1;
    sample();
    check("t5_cnt0", busy_cycles, 0);
    step();
    md_exception = 1'b0;
    sample();
    check("t5_cnt0_ignored", busy_cycles, 1);
    check("t5_cnt0_no_wb", wb_en, 0);
    step();
    md_ready = 1'b0;
    sample();
    check("t5_wb_en_rd0", wb_en, 0);
    check("t5_wb_sel", wb_sel_rstatus, 0);
    check("t5_wb_stall", stall, 0);
    check("t5_wb_busy", busy_cycles, 0);
    check("t5_no_wb_total", wben_cnt, 0);

    // ---- 6: reset mid-BUSY at cnt=4, then non-md issue ----
    step();
    step();
    issue(5'd0, 5'd6, 5'd11);
    step();
    issue_valid = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    sample();
    check("t6_cnt4", busy_cycles, 4);
    reset = 1'b0;
    #1;
    check("t6_rst_stall", stall, 0);
    check("t6_rst_busy", busy_cycles, 0);
    check("t6_rst_ctrl", {ctrl_mult, ctrl_div}, 0);
    check("t6_rst_wb", {wb_en, wb_sel_rstatus, wb_rd}, 0);
    step();
    reset = 1'b1;
    step();
    clear_counts();
    issue(5'd0, 5'd2, 5'd8);     // R-type, non-md aluop
    sample();
    check("t6_nonmd_stall", stall, 0);
    step();
    issue(5'd1, 5'd6, 5'd8);     // mul aluop but not R-type
    sample();
    check("t6_nonrtype_stall", stall, 0);
    step();
    issue_valid = 1'b0;
    sample();
    check("t6_idle_busy", busy_cycles, 0);
    check("t6_no_stall_total", stall_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
